// File: rtl/chess_move_clock.sv
// -----------------------------------------------------------------------------
// chess_move_clock
//   Per-player countdown clock for the timed chess game. Remaining time is held
//   in BCD as M:SS and counts down one second every CLOCK_FREQ cycles while run
//   is high. When the displayed time reaches 0:00 the block latches Timeout and
//   freezes until restart or resetApp.
//
// Optional feature (compile-time macro MOVE_CLOCK_INCREMENT_EN):
//   When defined, each moveDone pulse while running adds INCREMENT_SECS to the
//   remaining time (BCD carry, saturating at 9:59). When undefined, moveDone is
//   ignored and no adder is built.
//
// Ports:
//   clock        in   system clock, rising-edge
//   resetApp     in   asynchronous active-high reset
//   restart      in   synchronous reload to START_MINS:00 (overrides run/moveDone)
//   run          in   count-down enable (level)
//   moveDone     in   one-cycle pulse at the end of this player's move
//   SegMins      out  active-low 7-seg code (gfedcba) for the minutes digit
//   SegSecTens   out  active-low 7-seg code for the tens-of-seconds digit
//   SegSecUnits  out  active-low 7-seg code for the units-of-seconds digit
//   Timeout      out  high while the clock has expired
//   lowTime      out  high while remaining seconds <= LOW_TIME_SECS
// -----------------------------------------------------------------------------
module chess_move_clock #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int START_MINS     = 5,
  parameter int LOW_TIME_SECS  = 30,
  parameter int INCREMENT_SECS = 2
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       restart,
  input  logic       run,
  input  logic       moveDone,
  output logic [6:0] SegMins,
  output logic [6:0] SegSecTens,
  output logic [6:0] SegSecUnits,
  output logic       Timeout,
  output logic       lowTime
);

  // A one-cycle-per-second build still needs a 1-bit counter.
  localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PW-1:0] PRESCALE_TOP = PW'(CLOCK_FREQ - 1);
  localparam logic [3:0]    START_DIGIT  = 4'(START_MINS);
  localparam logic [9:0]    LOW_LIMIT    = 10'(LOW_TIME_SECS);

  typedef enum logic {
    RUNNING = 1'b0,
    EXPIRED = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [3:0]    mins, mins_next;
  logic [2:0]    tens, tens_next;
  logic [3:0]    units, units_next;
  logic [PW-1:0] prescale, prescale_next;
  logic          timeout, timeout_next;

  logic          tick;
  logic [10:0]   cur_time;
  logic [10:0]   dec_time;
  logic [10:0]   base_time;
  logic [9:0]    total_secs;

  // Active-low gfedcba decode; anything outside 0..9 blanks the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // One-second BCD decrement of a packed {mins, tens, units} value.
  function automatic logic [10:0] dec_bcd(input logic [10:0] t);
    logic [3:0] m;
    logic [2:0] tn;
    logic [3:0] u;
    m  = t[10:7];
    tn = t[6:4];
    u  = t[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (tn != 3'd0) begin
        tn = tn - 3'd1;
      end else begin
        tn = 3'd5;
        m  = m - 4'd1;
      end
    end
    return {m, tn, u};
  endfunction

`ifdef MOVE_CLOCK_INCREMENT_EN
  // Add INCREMENT_SECS with BCD carry; saturate at 9:59 on minute overflow.
  function automatic logic [10:0] add_increment(input logic [10:0] t);
    logic [4:0] u_sum;
    logic [3:0] t_sum;
    logic [4:0] m_sum;
    logic [10:0] result;
    u_sum = {1'b0, t[3:0]} + 5'(INCREMENT_SECS);
    if (u_sum > 5'd9) begin
      u_sum = u_sum - 5'd10;
      t_sum = {1'b0, t[6:4]} + 4'd1;
    end else begin
      t_sum = {1'b0, t[6:4]};
    end
    if (t_sum > 4'd5) begin
      t_sum = 4'd0;
      m_sum = {1'b0, t[10:7]} + 5'd1;
    end else begin
      m_sum = {1'b0, t[10:7]};
    end
    if (m_sum > 5'd9) begin
      result = {4'd9, 3'd5, 4'd9};
    end else begin
      result = {m_sum[3:0], t_sum[2:0], u_sum[3:0]};
    end
    return result;
  endfunction
`else
  // moveDone and INCREMENT_SECS have no function without the increment feature.
  logic [4:0] unused_inc;
  assign unused_inc = {moveDone, 4'(INCREMENT_SECS)};
`endif

  assign cur_time = {mins, tens, units};
  assign dec_time = dec_bcd(cur_time);

  // State and time registers; reset and restart load the same values.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state    <= RUNNING;
      mins     <= START_DIGIT;
      tens     <= 3'd0;
      units    <= 4'd0;
      prescale <= {PW{1'b0}};
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      mins     <= mins_next;
      tens     <= tens_next;
      units    <= units_next;
      prescale <= prescale_next;
      timeout  <= timeout_next;
    end
  end

  // Next-state logic: prescaler, BCD countdown, expiry and optional increment.
  always_comb begin
    state_next    = state;
    mins_next     = mins;
    tens_next     = tens;
    units_next    = units;
    prescale_next = prescale;
    timeout_next  = timeout;
    tick          = 1'b0;
    base_time     = cur_time;

    if (restart) begin
      state_next    = RUNNING;
      mins_next     = START_DIGIT;
      tens_next     = 3'd0;
      units_next    = 4'd0;
      prescale_next = {PW{1'b0}};
      timeout_next  = 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          // Pausing simply holds prescale so the fractional second survives.
          if (run) begin
            if (prescale == PRESCALE_TOP) begin
              tick          = 1'b1;
              prescale_next = {PW{1'b0}};
            end else begin
              prescale_next = prescale + PW'(1);
            end
          end else begin
            prescale_next = prescale;
          end

          if (tick && (dec_time == 11'd0)) begin
            // Expiry wins over any increment arriving on the same edge.
            state_next   = EXPIRED;
            timeout_next = 1'b1;
            mins_next    = 4'd0;
            tens_next    = 3'd0;
            units_next   = 4'd0;
          end else begin
            if (tick) begin
              base_time = dec_time;
            end else begin
              base_time = cur_time;
            end
`ifdef MOVE_CLOCK_INCREMENT_EN
            if (moveDone) begin
              {mins_next, tens_next, units_next} = add_increment(base_time);
            end else begin
              {mins_next, tens_next, units_next} = base_time;
            end
`else
            {mins_next, tens_next, units_next} = base_time;
`endif
          end
        end
        EXPIRED: begin
          state_next   = EXPIRED;
          timeout_next = 1'b1;
        end
        default: begin
          state_next = RUNNING;
        end
      endcase
    end
  end

  assign total_secs = (10'(mins) * 10'd60) + (10'(tens) * 10'd10) + 10'(units);
  assign lowTime    = (total_secs <= LOW_LIMIT);

  assign SegMins     = seg_decode(mins);
  assign SegSecTens  = seg_decode({1'b0, tens});
  assign SegSecUnits = seg_decode(units);
  assign Timeout     = timeout;

endmodule

// File: tb/tb_chess_move_clock.sv
// -----------------------------------------------------------------------------
// tb_chess_move_clock
//   Directed self-checking bench for chess_move_clock with CLOCK_FREQ=4 so one
//   displayed second is four clock cycles. A second instance with START_MINS=9
//   exercises increment saturation. Inputs are driven and outputs sampled on
//   the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_chess_move_clock;

  localparam logic [20:0] T1_00 = {7'h79, 7'h40, 7'h40};
  localparam logic [20:0] T0_59 = {7'h40, 7'h12, 7'h10};
  localparam logic [20:0] T0_58 = {7'h40, 7'h12, 7'h00};
  localparam logic [20:0] T0_57 = {7'h40, 7'h12, 7'h78};
  localparam logic [20:0] T0_31 = {7'h40, 7'h30, 7'h79};
  localparam logic [20:0] T0_30 = {7'h40, 7'h30, 7'h40};
  localparam logic [20:0] T0_01 = {7'h40, 7'h40, 7'h79};
  localparam logic [20:0] T0_00 = {7'h40, 7'h40, 7'h40};
  localparam logic [20:0] T9_00 = {7'h10, 7'h40, 7'h40};
  localparam logic [20:0] T9_59 = {7'h10, 7'h12, 7'h10};

  logic       clock = 1'b0;
  logic       resetApp;
  logic       restart, run, moveDone;
  logic [6:0] SegMins, SegSecTens, SegSecUnits;
  logic       Timeout, lowTime;

  logic       restart9, run9, moveDone9;
  logic [6:0] SegMins9, SegSecTens9, SegSecUnits9;
  logic       Timeout9, lowTime9;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  chess_move_clock #(
    .CLOCK_FREQ(4), .START_MINS(1), .LOW_TIME_SECS(30), .INCREMENT_SECS(2)
  ) dut (
    .clock(clock), .resetApp(resetApp), .restart(restart), .run(run),
    .moveDone(moveDone), .SegMins(SegMins), .SegSecTens(SegSecTens),
    .SegSecUnits(SegSecUnits), .Timeout(Timeout), .lowTime(lowTime)
  );

  chess_move_clock #(
    .CLOCK_FREQ(4), .START_MINS(9), .LOW_TIME_SECS(30), .INCREMENT_SECS(2)
  ) dut9 (
    .clock(clock), .resetApp(resetApp), .restart(restart9), .run(run9),
    .moveDone(moveDone9), .SegMins(SegMins9), .SegSecTens(SegSecTens9),
    .SegSecUnits(SegSecUnits9), .Timeout(Timeout9), .lowTime(lowTime9)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_restart;
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL reset_digits got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    checks++;
    if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b expected 0", Timeout); end
    checks++;
    if (lowTime !== 1'b0) begin errors++; $display("FAIL reset_lowtime got %b expected 0", lowTime); end
    checks++;
    if ({SegMins9, SegSecTens9, SegSecUnits9} !== T9_00) begin
      errors++; $display("FAIL reset_digits9 got %h expected %h", {SegMins9, SegSecTens9, SegSecUnits9}, T9_00);
    end
    resetApp = 1'b0;
    run = 1'b1;
    cycles(4);
    run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_59) begin
      errors++; $display("FAIL first_tick got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_59);
    end
  endtask

  task automatic test_pause;
    do_restart();
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL pause_restart got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    run = 1'b1; cycles(2);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL pause_run2 got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    run = 1'b0; cycles(10);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL pause_hold got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    run = 1'b1; cycles(1);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL pause_run3 got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    cycles(1);
    run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_59) begin
      errors++; $display("FAIL pause_tick got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_59);
    end
  endtask

  task automatic test_expiry_lowtime;
    do_restart();
    run = 1'b1;
    cycles(119);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, lowTime} !== {T0_31, 1'b0}) begin
      errors++; $display("FAIL low_031 got %h/%b expected %h/0", {SegMins, SegSecTens, SegSecUnits}, lowTime, T0_31);
    end
    cycles(1);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, lowTime} !== {T0_30, 1'b1}) begin
      errors++; $display("FAIL low_030 got %h/%b expected %h/1", {SegMins, SegSecTens, SegSecUnits}, lowTime, T0_30);
    end
    cycles(119);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, Timeout} !== {T0_01, 1'b0}) begin
      errors++; $display("FAIL pre_expiry got %h/%b expected %h/0", {SegMins, SegSecTens, SegSecUnits}, Timeout, T0_01);
    end
    cycles(1);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, Timeout, lowTime} !== {T0_00, 2'b11}) begin
      errors++; $display("FAIL expiry got %h/%b%b expected %h/11", {SegMins, SegSecTens, SegSecUnits}, Timeout, lowTime, T0_00);
    end
    moveDone = 1'b1; cycles(1); moveDone = 1'b0;
    cycles(19);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, Timeout, lowTime} !== {T0_00, 2'b11}) begin
      errors++; $display("FAIL expired_hold got %h/%b%b expected %h/11", {SegMins, SegSecTens, SegSecUnits}, Timeout, lowTime, T0_00);
    end
  endtask

  task automatic test_restart_expired;
    do_restart();
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, Timeout} !== {T1_00, 1'b0}) begin
      errors++; $display("FAIL restart_expired got %h/%b expected %h/0", {SegMins, SegSecTens, SegSecUnits}, Timeout, T1_00);
    end
    run = 1'b0;
    cycles(1);
  endtask

  task automatic test_async_reset;
    run = 1'b1; cycles(6); run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_59) begin
      errors++; $display("FAIL async_pre got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_59);
    end
    resetApp = 1'b1;
    #1;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits, Timeout} !== {T1_00, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h/%b expected %h/0", {SegMins, SegSecTens, SegSecUnits}, Timeout, T1_00);
    end
    cycles(1);
    resetApp = 1'b0;
    run = 1'b1; cycles(3);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T1_00) begin
      errors++; $display("FAIL async_prescale_cleared got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T1_00);
    end
    cycles(1); run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_59) begin
      errors++; $display("FAIL async_first_tick got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_59);
    end
  endtask

  task automatic test_move_increment;
    logic [20:0] exp_a, exp_b, exp_c;
`ifdef MOVE_CLOCK_INCREMENT_EN
    exp_a = T1_00; exp_b = T0_59; exp_c = T9_59;
`else
    exp_a = T0_58; exp_b = T0_57; exp_c = T9_00;
`endif
    do_restart();
    run = 1'b1; cycles(8); run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_58) begin
      errors++; $display("FAIL move_pre got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_58);
    end
    moveDone = 1'b1; cycles(1); moveDone = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== exp_a) begin
      errors++; $display("FAIL move_add got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, exp_a);
    end
    do_restart();
    run = 1'b1; cycles(11);
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== T0_58) begin
      errors++; $display("FAIL move_tick_pre got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, T0_58);
    end
    moveDone = 1'b1; cycles(1); moveDone = 1'b0; run = 1'b0;
    checks++;
    if ({SegMins, SegSecTens, SegSecUnits} !== exp_b) begin
      errors++; $display("FAIL move_with_tick got %h expected %h", {SegMins, SegSecTens, SegSecUnits}, exp_b);
    end
    run9 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      moveDone9 = 1'b1; cycles(1);
      moveDone9 = 1'b0; cycles(1);
    end
    checks++;
    if ({SegMins9, SegSecTens9, SegSecUnits9, Timeout9} !== {exp_c, 1'b0}) begin
      errors++; $display("FAIL move_saturate got %h/%b expected %h/0", {SegMins9, SegSecTens9, SegSecUnits9}, Timeout9, exp_c);
    end
  endtask

  initial begin
    resetApp  = 1'b1;
    restart   = 1'b0;
    run       = 1'b0;
    moveDone  = 1'b0;
    restart9  = 1'b0;
    run9      = 1'b0;
    moveDone9 = 1'b0;
    cycles(2);
    test_reset();
    test_pause();
    test_expiry_lowtime();
    test_restart_expired();
    test_async_reset();
    test_move_increment();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
